// File: rtl/alu_x4.sv
// alu_x4: 4-bit, 8-operation ALU with registered result and carry flag
module alu_x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ALU_option,
    input  logic [3:0] ALU_in1,
    input  logic [3:0] ALU_in2,
    output logic [3:0] ALU_out,
    output logic       ALU_Cout
);
    logic [4:0] res_d, res_q;
    // Next {carry, result}; unknown opcodes fall into the zero default
    always_comb begin
        res_d = 5'd0;
        case (ALU_option)
            3'b000:  res_d = {1'b0, ALU_in1} + {1'b0, ALU_in2};
            3'b001:  res_d = {1'b0, ALU_in1} + {1'b0, ~ALU_in2} + 5'd1;
            3'b010:  res_d = {1'b0, ALU_in1 & ALU_in2};
            3'b011:  res_d = {1'b0, ALU_in1 | ALU_in2};
            3'b100:  res_d = {1'b0, ~ALU_in1};
            3'b101:  res_d = {1'b0, ALU_in1 ^ ALU_in2};
            3'b110:  res_d = {1'b0, ~ALU_in1} + 5'd1;
            3'b111:  res_d = {ALU_in1, 1'b0};
            default: res_d = 5'd0;
        endcase
    end
    // Output register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) res_q <= 5'd0;
        else     res_q <= res_d;
    end
    assign {ALU_Cout, ALU_out} = res_q;
endmodule

// File: tb/tb_alu_x4.sv
// tb_alu_x4: randomized and directed checks of alu_x4 against an arithmetic model
module tb_alu_x4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ALU_option = 3'd0;
    logic [3:0] ALU_in1 = 4'd0;
    logic [3:0] ALU_in2 = 4'd0;
    logic [3:0] ALU_out;
    logic       ALU_Cout;
    int checks = 0;
    int errors = 0;

    alu_x4 dut (
        .clk(clk),
        .rst(rst),
        .ALU_option(ALU_option),
        .ALU_in1(ALU_in1),
        .ALU_in2(ALU_in2),
        .ALU_out(ALU_out),
        .ALU_Cout(ALU_Cout)
    );

    always #5 clk = ~clk;

    // Reference: returns {cout, out} computed with plain integer arithmetic
    function automatic logic [4:0] model(input int op, input int a, input int b);
        int o;
        int c;
        o = 0;
        c = 0;
        case (op)
            0: begin o = (a + b) % 16; c = (a + b) > 15; end
            1: begin o = (a - b + 16) % 16; c = (a >= b); end
            2: o = a & b;
            3: o = a | b;
            4: o = 15 - a;
            5: o = a ^ b;
            6: begin o = (16 - a) % 16; c = (a == 0); end
            7: begin o = (a * 2) % 16; c = (a >= 8); end
            default: o = 0;
        endcase
        return 5'((c << 4) | o);
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cout=%0b out=%b, expected cout=%0b out=%b",
                     tag, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    // Apply one operation, clock it in, and check the registered result
    task automatic run_op(input string tag, input int op, input int a, input int b);
        ALU_option = 3'(op);
        ALU_in1 = 4'(a);
        ALU_in2 = 4'(b);
        @(posedge clk);
        #1;
        check(tag, {ALU_Cout, ALU_out}, rst ? 5'd0 : model(op, a, b));
    endtask

    initial begin
        logic [4:0] held;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) run_op("reset", 0, 15, 15);
        rst = 1'b0;
        run_op("add_c_9", 0, 12, 9);
        check("add_c_9_const", {ALU_Cout, ALU_out}, 5'b10101);
        run_op("add_f_f", 0, 15, 15);
        run_op("add_4_8", 0, 4, 8);
        run_op("sub_8_4", 1, 8, 4);
        run_op("sub_4_8", 1, 4, 8);
        check("sub_4_8_const", {ALU_Cout, ALU_out}, 5'b01100);
        run_op("sub_a_a", 1, 10, 10);
        run_op("and", 2, 12, 9);
        run_op("or", 3, 12, 9);
        run_op("xor", 5, 12, 9);
        run_op("not", 4, 12, 9);
        check("not_const", {ALU_Cout, ALU_out}, 5'b00011);
        run_op("neg_4", 6, 4, 7);
        run_op("neg_0", 6, 0, 7);
        check("neg_0_const", {ALU_Cout, ALU_out}, 5'b10000);
        run_op("neg_8", 6, 8, 0);
        run_op("shl_c", 7, 12, 3);
        run_op("shl_2", 7, 2, 3);
        held = {ALU_Cout, ALU_out};
        ALU_option = 3'd0;
        ALU_in1 = 4'd15;
        ALU_in2 = 4'd15;
        #3;
        check("hold_between_edges", {ALU_Cout, ALU_out}, held);
        run_op("b2b_add", 0, 7, 9);
        run_op("b2b_sub", 1, 3, 5);
        run_op("b2b_shl", 7, 9, 0);
        rst = 1'b1;
        run_op("mid_reset", 0, 15, 1);
        rst = 1'b0;
        run_op("after_reset", 0, 15, 1);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            run_op("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)));
        end
        rst = 1'b0;
        for (int op = 0; op < 8; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b += 5) run_op("sweep", op, a, b);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
